// File: rtl/addsub_seq.sv
`default_nettype none
// ============================================================================
//  Module   : addsub_seq
//  Purpose  : Multi-cycle WIDTH-bit add/subtract that processes CHUNK bits per
//             clock and carries between chunks in a register. It has a
//             start/busy/done handshake, signed overflow and zero flags, and
//             optional signed saturation.
//             result = b + (a ^ {WIDTH{op}}) + xin  (mod 2^WIDTH)
//  Ports    : clk, rst_n      clock, asynchronous active-low reset
//             start          request, accepted in IDLE or DONE
//             a, b           operands (a inverted internally when op=1)
//             xin            carry/borrow into chunk 0
//             op             0 = add, 1 = subtract
//             sat            signed saturation on overflow
//             busy           high while chunks are being processed
//             done           one-cycle pulse, results valid
//             s_d            result, held until the next operation completes
//             co_bo          raw carry-out of the MSB (0 = borrow on subtract)
//             ovf            signed overflow of the raw result
//             zero           s_d == 0 (after saturation)
//  Revision : 1.0  initial release
// ============================================================================
module addsub_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             xin,
    input  logic             op,
    input  logic             sat,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s_d,
    output logic             co_bo,
    output logic             ovf,
    output logic             zero
);

    localparam int               c_N       = WIDTH / CHUNK;
    localparam int               c_CNT_W   = (c_N > 1) ? $clog2(c_N) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(c_N - 1);
    localparam logic [WIDTH-1:0] c_POS_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] c_NEG_MAX = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    logic [WIDTH-1:0]     r_a_sh;     // operand a (already conditionally inverted), shifted right per chunk
    logic [WIDTH-1:0]     r_b_sh;     // operand b, shifted right per chunk
    logic [WIDTH-1:0]     r_acc;      // result chunks enter at the top and shift down
    logic                 r_carry;
    logic                 r_sat;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]     r_s_d;
    logic                 r_co_bo;
    logic                 r_ovf;
    logic                 r_zero;

    logic                 w_accept;
    logic                 w_last;
    logic [CHUNK:0]       w_sum;
    logic [CHUNK-1:0]     w_chunk;
    logic                 w_cout;
    logic                 w_msb_cin;
    logic                 w_ovf;
    logic [WIDTH-1:0]     w_acc_next;
    logic [WIDTH-1:0]     w_final;

    assign w_accept = start && (r_state != S_RUN);
    assign w_last   = (r_state == S_RUN) && (r_cnt == c_LAST);

    // ------------------------------------------------------------------
    // Chunk adder
    // ------------------------------------------------------------------
    assign w_sum   = {1'b0, r_a_sh[CHUNK-1:0]} + {1'b0, r_b_sh[CHUNK-1:0]}
                   + (CHUNK+1)'(r_carry);
    assign w_chunk = w_sum[CHUNK-1:0];
    assign w_cout  = w_sum[CHUNK];

    // Carry into the chunk's top bit recovered from sum ^ a ^ b; only
    // meaningful on the last chunk, where that bit is the word MSB.
    assign w_msb_cin = w_chunk[CHUNK-1] ^ r_a_sh[CHUNK-1] ^ r_b_sh[CHUNK-1];
    assign w_ovf     = w_msb_cin ^ w_cout;

    // After N shifts the first chunk has reached bit 0. The shift forms
    // also stay legal when CHUNK == WIDTH.
    assign w_acc_next = (r_acc >> CHUNK) | (WIDTH'(w_chunk) << (WIDTH - CHUNK));

    always_comb begin
        w_final = w_acc_next;
        if (r_sat && w_ovf) begin
            w_final = w_chunk[CHUNK-1] ? c_POS_MAX : c_NEG_MAX;
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_RUN;
            S_RUN:   if (r_cnt == c_LAST) w_state_next = S_DONE;
            S_DONE:  w_state_next = start ? S_RUN : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_sat   <= 1'b0;
            r_cnt   <= '0;
            r_s_d   <= '0;
            r_co_bo <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
        end else if (w_accept) begin
            r_a_sh  <= a ^ {WIDTH{op}};
            r_b_sh  <= b;
            r_acc   <= '0;
            r_carry <= xin;
            r_sat   <= sat;
            r_cnt   <= '0;
        end else if (r_state == S_RUN) begin
            r_a_sh  <= r_a_sh >> CHUNK;
            r_b_sh  <= r_b_sh >> CHUNK;
            r_acc   <= w_acc_next;
            r_carry <= w_cout;
            r_cnt   <= r_cnt + c_CNT_W'(1);
            if (w_last) begin
                r_s_d   <= w_final;
                r_co_bo <= w_cout;
                r_ovf   <= w_ovf;
                r_zero  <= (w_final == '0);
            end
        end
    end

    assign busy  = (r_state == S_RUN);
    assign done  = (r_state == S_DONE);
    assign s_d   = r_s_d;
    assign co_bo = r_co_bo;
    assign ovf   = r_ovf;
    assign zero  = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_addsub_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_addsub_seq
//  Purpose  : Self-checking bench for addsub_seq (WIDTH=16, CHUNK=4): directed
//             cases, handshake and reset scenarios, then random operations
//             compared against an arithmetic reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_addsub_seq;

    localparam int c_W = 16;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [c_W-1:0] a;
    logic [c_W-1:0] b;
    logic           xin;
    logic           op;
    logic           sat;
    logic           busy;
    logic           done;
    logic [c_W-1:0] s_d;
    logic           co_bo;
    logic           ovf;
    logic           zero;

    int             n_cmp;
    int             n_bad;
    logic [c_W-1:0] prev_sd;

    addsub_seq #(.WIDTH(16), .CHUNK(4)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .xin   (xin),
        .op    (op),
        .sat   (sat),
        .busy  (busy),
        .done  (done),
        .s_d   (s_d),
        .co_bo (co_bo),
        .ovf   (ovf),
        .zero  (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: {zero, ovf, co, s_d}
    function automatic logic [18:0] model(input logic [15:0] ia, input logic [15:0] ib,
                                          input logic ixin, input logic iop, input logic isat);
        logic [15:0] x;
        logic [16:0] full;
        logic [15:0] r;
        logic        v;
        x    = iop ? ~ia : ia;
        full = {1'b0, ib} + {1'b0, x} + 17'(ixin);
        r    = full[15:0];
        // signed overflow: operands share a sign that the result lacks
        v    = (x[15] == ib[15]) && (r[15] != ib[15]);
        if (isat && v) r = r[15] ? 16'h7FFF : 16'h8000;
        return {(r == 16'h0), v, full[16], r};
    endfunction

    task automatic check_result(input string tag, input logic [18:0] e);
        check({tag, ".s_d"},   32'(s_d),   32'(e[15:0]));
        check({tag, ".co_bo"}, 32'(co_bo), 32'(e[16]));
        check({tag, ".ovf"},   32'(ovf),   32'(e[17]));
        check({tag, ".zero"},  32'(zero),  32'(e[18]));
    endtask

    task automatic drive(input logic [15:0] ia, input logic [15:0] ib,
                         input logic ixin, input logic iop, input logic isat);
        a = ia; b = ib; xin = ixin; op = iop; sat = isat;
    endtask

    // Full operation: start, watch RUN, check latency/pulse/outputs.
    // poke=1 re-pulses start with other operands during RUN.
    task automatic do_op(input string tag, input logic [15:0] ia, input logic [15:0] ib,
                         input logic ixin, input logic iop, input logic isat, input bit poke);
        logic [18:0] e;
        int          n;
        e = model(ia, ib, ixin, iop, isat);
        @(negedge clk);
        drive(ia, ib, ixin, iop, isat);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drive(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            check({tag, ".busy"}, 32'(busy), 32'd1);
            if (n == 0) check({tag, ".hold"}, 32'(s_d), 32'(prev_sd));
            start = (poke && n == 1);
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check({tag, ".latency"}, 32'(n), 32'd4);
        check({tag, ".busy_in_done"}, 32'(busy), 32'd0);
        check_result(tag, e);
        prev_sd = e[15:0];
        @(negedge clk);
        check({tag, ".done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        logic [18:0] e1;
        logic [18:0] e2;
        int          n;

        n_cmp = 0; n_bad = 0; prev_sd = '0;
        rst_n = 1'b0; start = 1'b0;
        drive(16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check_result("rst", 19'h0);
        rst_n = 1'b1;

        do_op("add",    16'h1234, 16'h0F0F, 1'b0, 1'b0, 1'b0, 1'b0);
        do_op("sub1",   16'h0005, 16'h0003, 1'b1, 1'b1, 1'b0, 1'b0);
        do_op("sub2",   16'h0003, 16'h0005, 1'b1, 1'b1, 1'b0, 1'b0);
        do_op("carry",  16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        do_op("ovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
        do_op("satpos", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0);
        do_op("satneg", 16'h8000, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b0);
        do_op("poke",   16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0, 1'b1);

        // Back-to-back: start held during the DONE cycle
        e1 = model(16'h0100, 16'h0020, 1'b0, 1'b0, 1'b0);
        e2 = model(16'h00FF, 16'h0F00, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        drive(16'h0100, 16'h0020, 1'b0, 1'b0, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("b2b.first_done", 32'(done), 32'd1);
        check_result("b2b.first", e1);
        drive(16'h00FF, 16'h0F00, 1'b1, 1'b1, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("b2b.busy_next", 32'(busy), 32'd1);
        n = 1;
        while (done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("b2b.spacing", 32'(n), 32'd5);
        check_result("b2b.second", e2);
        prev_sd = e2[15:0];
        @(negedge clk);

        // Reset during the second RUN cycle
        drive(16'h4321, 16'h1111, 1'b0, 1'b0, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("arst.busy", 32'(busy), 32'd0);
        check("arst.done", 32'(done), 32'd0);
        check_result("arst", 19'h0);
        @(negedge clk);
        rst_n = 1'b1;
        prev_sd = '0;
        n = 0;
        repeat (8) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) n++;
        end
        check("arst.quiet", 32'(n), 32'd0);
        do_op("post_rst", 16'h1234, 16'h0F0F, 1'b0, 1'b0, 1'b0, 1'b0);

        // Random operations
        for (int i = 0; i < 40; i++) begin
            do_op("rand", 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/addsub_seq.md
Name: addsub_seq

Overview:
- Parametrised, multi-cycle successor to the team's 4-bit ripple add/sub.
- Computes a WIDTH-bit add or subtract CHUNK bits per clock, carrying between chunks in a register.
- Adds a start/busy/done handshake, signed overflow and zero flags, and optional signed saturation.
- Used by datapaths that need wide arithmetic without a long combinational carry chain.

Parameters:
WIDTH  16  operand/result width; WIDTH >= 2; must be an integer multiple of CHUNK
CHUNK  4   bits processed per clock; 1 <= CHUNK <= WIDTH
(derived) N = WIDTH/CHUNK chunk cycles per operation

Ports:
clk    input   1      single clock, rising edge
rst_n  input   1      asynchronous, active-low reset
start  input   1      request; accepted only when not busy
a      input   WIDTH  operand a; inverted internally when op=1
b      input   WIDTH  operand b
xin    input   1      carry-in/borrow-in to chunk 0
op     input   1      0 = add, 1 = subtract
sat    input   1      1 = signed saturation on overflow
busy   output  1      operation in progress
done   output  1      one-cycle pulse, result valid
s_d    output  WIDTH  sum/difference, held until next accepted start completes
co_bo  output  1      raw carry-out of MSB
ovf    output  1      signed overflow of raw result
zero   output  1      s_d == 0

Behaviour:
- Arithmetic: result = b + (a XOR {WIDTH{op}}) + xin, mod 2^WIDTH.
  - op=1, xin=1 gives b - a.
  - co_bo is the raw carry-out: for subtract, co_bo=0 means a borrow occurred.
- Reset (rst_n low, any time, asynchronous): state=IDLE; busy, done, s_d, co_bo, ovf, zero = 0; chunk counter and carry register cleared. Any in-flight operation is discarded and no done is issued.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 at an edge latches a, b, xin, op, sat into internal registers, sets carry reg = xin and cnt = 0, then goes to RUN.
  - RUN: each edge adds chunk cnt (bits cnt*CHUNK+CHUNK-1 .. cnt*CHUNK) using the carry reg. It writes the chunk sum into the result shift/accumulate register, updates the carry reg, and increments cnt.
    - On the edge processing chunk N-1, final values are registered into s_d, co_bo, ovf and zero, and the FSM goes to DONE.
  - DONE: done=1 for exactly this one cycle.
    - start=1 at this edge is accepted (back-to-back): RUN is entered with new operands.
    - Otherwise the FSM returns to IDLE.
- busy=1 in RUN only.
- start while busy is ignored: no effect, no queuing.
- Inputs a, b, xin, op, sat are don't-care except at the accepting edge.
- Latency: start accepted at edge E0; done high during the cycle after edge EN. There are exactly N edges in RUN.
- Throughput: one operation per N+1 cycles.
- ovf = carry into MSB XOR carry out of MSB, computed on the raw result. ovf is reported regardless of sat.
- Saturation (latched sat=1 and ovf=1):
  - s_d = 0111..1 if raw MSB=1 (positive overflow).
  - s_d = 1000..0 if raw MSB=0 (negative overflow).
  - co_bo is unchanged (raw).
- zero is evaluated on the final s_d, after saturation.
- s_d, co_bo, ovf and zero update only at the completing edge. They are stable otherwise, including during RUN.
- CHUNK=WIDTH is legal: N=1, single RUN cycle.

Test Plan (WIDTH=16, CHUNK=4, N=4):
1. Add: start with a=0x1234, b=0x0F0F, xin=0, op=0, sat=0 -> busy high for 4 cycles; done pulse 1 cycle; s_d=0x2143, co_bo=0, ovf=0, zero=0.
2. Subtract: a=0x0005, b=0x0003, op=1, xin=1 -> s_d=0xFFFE, co_bo=0 (borrow), ovf=0. Repeat with a=0x0003, b=0x0005 -> s_d=0x0002, co_bo=1.
3. Cross-chunk carry: a=0xFFFF, b=0x0000, xin=1, op=0 -> s_d=0x0000, co_bo=1, zero=1, ovf=0.
4. Overflow/saturation:
   - a=0x7FFF, b=0x0001, op=0: sat=0 -> s_d=0x8000, ovf=1; sat=1 -> s_d=0x7FFF, ovf=1.
   - a=0x8000, b=0x8000, sat=1 -> s_d=0x8000, co_bo=1, ovf=1.
5. Handshake:
   - Pulse start again during RUN with different operands -> ignored; result is from the first operands.
   - Assert start in the DONE cycle -> new op accepted, busy rises next cycle, second done exactly 5 edges after the first.
6. Reset mid-op: drop rst_n during the 2nd RUN cycle -> all outputs 0 immediately. After release: no done, FSM in IDLE, next start behaves as in scenario 1.
